// File: rtl/fifo_tx_drain_ctrl.sv
// Read-side drain sequencer: pops the async FIFO and hands bytes to UART TX one frame at a time.
// Optional inter-frame gap (GAP state, GAP_CYCLES port) is built when FRAME_GAP_EN is defined.
module fifo_tx_drain_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RDATA,
  output logic                  RD_INC,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic                  CTRL_IDLE
`ifdef FRAME_GAP_EN
  ,
  input  logic [7:0]            GAP_CYCLES
`endif
);

  localparam int unsigned LAT_W = 2;
  localparam int unsigned GAP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_DONE = 3'd4
`ifdef FRAME_GAP_EN
    ,
    S_GAP       = 3'd5
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic                  rd_inc_q, rd_inc_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  ctrl_idle_q, ctrl_idle_d;

  // Next-state and next-output logic; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (EN && !FIFO_EMPTY && !TX_BUSY) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        lat_cnt_d = LAT_W'(RD_LAT - 1);
        state_d   = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (lat_cnt_q == '0) begin
          tx_data_d = FIFO_RDATA;
          state_d   = S_SEND;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_SEND: begin
        if (TX_BUSY) begin
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          state_d     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!TX_BUSY) begin
`ifdef FRAME_GAP_EN
          if (GAP_CYCLES != 8'd0) begin
            gap_cnt_d = GAP_CYCLES;
            state_d   = S_GAP;
          end else begin
            state_d   = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef FRAME_GAP_EN
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_inc_d    = (state_d == S_POP);
    tx_valid_d  = (state_d == S_SEND);
    ctrl_idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
      rd_inc_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      ctrl_idle_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
      rd_inc_q    <= rd_inc_d;
      tx_valid_q  <= tx_valid_d;
      ctrl_idle_q <= ctrl_idle_d;
    end
  end

  assign RD_INC        = rd_inc_q;
  assign TX_P_DATA     = tx_data_q;
  assign TX_DATA_VALID = tx_valid_q;
  assign FRAME_CNT     = frame_cnt_q;
  assign CTRL_IDLE     = ctrl_idle_q;

endmodule

// File: doc/fifo_tx_drain_ctrl.md
Name: fifo_tx_drain_ctrl

Overview:
Read-side sequencer that drains the async FIFO into the UART transmitter, in the UART TX clock domain. Watches the FIFO empty flag, issues single-cycle read-increment pulses, and captures the read data after a fixed memory latency. Presents each byte to UART TX with a valid/busy handshake, and enforces one frame in flight at a time.

Parameters:
DATA_WIDTH, 8, width of FIFO read data and UART parallel data
RD_LAT, 1, cycles from the RD_INC pulse to valid FIFO_RDATA (legal 1..3)
CNT_WIDTH, 16, width of the sent-frame counter

Ports:
CLK  input  1  UART TX domain clock
RST  input  1  asynchronous reset, active-low
EN  input  1  drain enable; sampled only in IDLE
FIFO_EMPTY  input  1  FIFO empty flag, already synchronised to CLK
FIFO_RDATA  input  DATA_WIDTH  FIFO read data
RD_INC  output  1  FIFO read-pointer increment, one-cycle pulse
TX_BUSY  input  1  UART TX busy (high while a frame shifts out)
TX_P_DATA  output  DATA_WIDTH  registered byte presented to UART TX
TX_DATA_VALID  output  1  byte-valid to UART TX
FRAME_CNT  output  CNT_WIDTH  frames handed to UART TX since reset, wraps
CTRL_IDLE  output  1  high only in the IDLE state
GAP_CYCLES  input  8  inter-frame gap length; present only with FRAME_GAP_EN

Behaviour:
- Reset (RST low, async): state IDLE; RD_INC=0, TX_P_DATA=0, TX_DATA_VALID=0, FRAME_CNT=0, CTRL_IDLE=1; latency counter and gap counter = 0.
- All outputs are registered. No combinational path exists from any input to any output.
- IDLE: if EN=1 and FIFO_EMPTY=0 and TX_BUSY=0, go to POP. Otherwise stay in IDLE.
- POP: RD_INC=1 for exactly this one cycle. Load the latency counter with RD_LAT-1. Go to WAIT_DATA.
- WAIT_DATA: RD_INC=0. Count down. When the count reaches 0, register FIFO_RDATA into TX_P_DATA on that edge and go to SEND.
- Latency rule: TX_P_DATA captures the RD_LAT-th rising edge after the RD_INC-high cycle.
- SEND: TX_DATA_VALID=1. Valid holds until TX_BUSY=1 is sampled. On that cycle: TX_DATA_VALID drops, FRAME_CNT increments by 1 (modulo 2^CNT_WIDTH), and the state goes to WAIT_DONE.
- TX_P_DATA is stable from SEND entry until the next POP.
- WAIT_DONE: wait for TX_BUSY=0. Then go to GAP if FRAME_GAP_EN is compiled in and GAP_CYCLES!=0. Otherwise go to IDLE.
- Back-to-back drain: with the FIFO continuously non-empty, a new POP starts 1 cycle after TX_BUSY falls, which is the IDLE re-evaluation cycle.
- Empty boundary: FIFO_EMPTY is examined only in IDLE. Once POP is taken, the frame always completes.
- EN deasserted mid-frame: the current frame completes. The controller then parks in IDLE.
- TX_BUSY high while in IDLE, e.g. left over from an earlier transfer: no POP is issued until it is low.
- Exactly one RD_INC pulse is issued per frame. RD_INC is never high in two consecutive cycles.
- Reset mid-operation: immediate return to the reset values. Any partially read byte is discarded; the FIFO pointer has already advanced.
- Illegal/unused state encodings return to IDLE on the next edge.

Optional Feature:
Macro: FRAME_GAP_EN
- With the macro: GAP_CYCLES port and GAP state exist.
- GAP: loads GAP_CYCLES on entry, counts down one per cycle, and goes to IDLE when the count reaches 0. This inserts exactly GAP_CYCLES idle cycles between TX_BUSY falling and the IDLE re-evaluation.
- GAP_CYCLES is sampled on GAP entry only.
- Without the macro: no GAP_CYCLES port and no GAP state. WAIT_DONE goes directly to IDLE.

Test Plan:
- Reset check: assert RST mid-SEND with TX_DATA_VALID=1 -> all outputs return to reset values asynchronously; FRAME_CNT=0.
- Single byte, RD_LAT=1, FIFO holds 0xA5, EN=1, TX model asserts busy 2 cycles after valid for 10 cycles -> one RD_INC pulse; TX_P_DATA=0xA5 one edge after the pulse; valid held until busy; FRAME_CNT=1; back in IDLE.
- Burst: 4 bytes 0x11,0x22,0x33,0x44, RD_LAT=2 -> four RD_INC pulses, each 1 cycle after TX_BUSY falls; bytes delivered in order; FRAME_CNT=4; stop when FIFO_EMPTY=1.
- EN dropped during WAIT_DATA with 3 bytes queued -> current byte delivered; no further RD_INC; CTRL_IDLE=1.
- FRAME_GAP_EN built, GAP_CYCLES=5, 2 bytes queued -> exactly 5 idle cycles plus 1 IDLE cycle between TX_BUSY falling and the second RD_INC.
- Counter wrap: CNT_WIDTH=4, send 17 frames -> FRAME_CNT=1; TX_BUSY held high at start -> no RD_INC until it is released.
